// File: rtl/sram_fetch.sv
// Block read engine: streams an image block or the next coefficient set out of
// external SRAM, tags each returned word with its index, and pulses sram_done at the end.
module sram_fetch #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int IMG_BASE   = 0,
    parameter int IMG_WORDS  = 64,
    parameter int COEF_BASE  = 1024,
    parameter int COEF_WORDS = 16,
    parameter int COEF_SETS  = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_sram,
    input  logic              n_coef_image,
    output logic              sram_ren,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       out_index,
    output logic              out_is_image,
    output logic              sram_done,
    output logic              busy
);
    localparam int CS_W = (COEF_SETS > 1) ? $clog2(COEF_SETS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state;
    state_t                state_next;
    logic [CS_W-1:0]       coef_set;
    logic [15:0]           len;
    logic [15:0]           issue_cnt;
    logic [15:0]           ret_cnt;
    logic [RD_LATENCY-1:0] rd_vld;
    logic [ADDR_W-1:0]     coef_addr;
    logic                  last_issue;
    logic                  last_ret;

    assign coef_addr  = ADDR_W'(COEF_BASE) + ADDR_W'(coef_set) * ADDR_W'(COEF_WORDS);
    assign last_issue = (issue_cnt == len - 16'd1);
    assign last_ret   = out_valid && (out_index == len - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_sram) state_next = ISSUE;
            ISSUE:   if (last_issue) state_next = DRAIN;
            DRAIN:   if (last_ret)   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Issue side: fetch type, length and base are frozen in the start cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_ren     <= 1'b0;
            sram_addr    <= '0;
            out_is_image <= 1'b0;
            len          <= '0;
            issue_cnt    <= '0;
            coef_set     <= '0;
            sram_done    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sram_done <= (state_next == DONE);
            busy      <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (start_sram) begin
                        out_is_image <= n_coef_image;
                        len          <= n_coef_image ? 16'(IMG_WORDS) : 16'(COEF_WORDS);
                        sram_addr    <= n_coef_image ? ADDR_W'(IMG_BASE) : coef_addr;
                        sram_ren     <= 1'b1;
                        issue_cnt    <= '0;
                    end
                end
                ISSUE: begin
                    if (last_issue) begin
                        sram_ren <= 1'b0;
                    end else begin
                        sram_addr <= sram_addr + ADDR_W'(1);
                        issue_cnt <= issue_cnt + 16'd1;
                    end
                end
                DONE: begin
                    // A new image always restarts the coefficient sequence at set 0
                    if (out_is_image || coef_set == CS_W'(COEF_SETS - 1)) begin
                        coef_set <= '0;
                    end else begin
                        coef_set <= coef_set + CS_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Return side: rd_vld mirrors sram_ren delayed to the cycle its data is on sram_rdata
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            ret_cnt   <= '0;
        end else begin
            rd_vld    <= (rd_vld << 1) | RD_LATENCY'(sram_ren);
            out_valid <= rd_vld[RD_LATENCY-1];
            if (state == IDLE && start_sram) begin
                ret_cnt <= '0;
            end else if (rd_vld[RD_LATENCY-1]) begin
                out_data  <= sram_rdata;
                out_index <= ret_cnt;
                ret_cnt   <= ret_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_sram_fetch.sv
// Bench for sram_fetch: cycle-exact schedule model driven by random and directed fetch requests.
module tb_sram_fetch;
    localparam int L      = 2;
    localparam int IMG_N  = 4;
    localparam int COEF_N = 16;
    localparam int COEF_B = 1024;
    localparam int SETS   = 2;

    logic        clk;
    logic        rst;
    logic        start_sram;
    logic        n_coef_image;
    logic        sram_ren;
    logic [15:0] sram_addr;
    logic [15:0] sram_rdata;
    logic        out_valid;
    logic [15:0] out_data;
    logic [15:0] out_index;
    logic        out_is_image;
    logic        sram_done;
    logic        busy;

    logic        st1, ren1, val1, img1, done1, busy1;
    logic [15:0] addr1, rdata1, data1, idx1;
    logic        st4, ren4, val4, img4, done4, busy4;
    logic [15:0] addr4, rdata4, data4, idx4;

    int n_chk;
    int n_pass;
    int cyc;

    // Reference model: one record of the most recently accepted fetch
    bit have_f;
    bit img_m;
    bit prev_img;
    int s_m;
    int n_m;
    int base_m;
    int cs_m;

    sram_fetch #(.ADDR_W(16), .DATA_W(16), .IMG_BASE(0), .IMG_WORDS(IMG_N),
                 .COEF_BASE(COEF_B), .COEF_WORDS(COEF_N), .COEF_SETS(SETS),
                 .RD_LATENCY(L)) u_main (
        .clk(clk), .rst(rst), .start_sram(start_sram), .n_coef_image(n_coef_image),
        .sram_ren(sram_ren), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
        .out_is_image(out_is_image), .sram_done(sram_done), .busy(busy));

    sram_fetch #(.IMG_BASE(0), .IMG_WORDS(1), .RD_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .start_sram(st1), .n_coef_image(1'b1),
        .sram_ren(ren1), .sram_addr(addr1), .sram_rdata(rdata1),
        .out_valid(val1), .out_data(data1), .out_index(idx1),
        .out_is_image(img1), .sram_done(done1), .busy(busy1));

    sram_fetch #(.IMG_BASE(0), .IMG_WORDS(1), .RD_LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .start_sram(st4), .n_coef_image(1'b1),
        .sram_ren(ren4), .sram_addr(addr4), .sram_rdata(rdata4),
        .out_valid(val4), .out_data(data4), .out_index(idx4),
        .out_is_image(img4), .sram_done(done4), .busy(busy4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM models: word at address a reads back as a ^ A5A5, L cycles after the read
    logic [15:0] pm [0:1];
    logic [15:0] p4 [0:3];
    logic [15:0] p1;
    always @(posedge clk) begin
        pm[0] <= sram_ren ? (sram_addr ^ 16'hA5A5) : 16'hDEAD;
        pm[1] <= pm[0];
        p1    <= ren1 ? (addr1 ^ 16'hA5A5) : 16'hDEAD;
        p4[0] <= ren4 ? (addr4 ^ 16'hA5A5) : 16'hDEAD;
        for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
    end
    assign sram_rdata = pm[1];
    assign rdata1     = p1;
    assign rdata4     = p4[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Per-cycle comparison of the main DUT against the expected schedule
    always @(negedge clk) begin
        int  k;
        bit  e_ren, e_val, e_done, e_busy, e_img;
        if (rst) begin
            chk("rst_ren", sram_ren, 0);
            chk("rst_addr", sram_addr, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_data", out_data, 0);
            chk("rst_index", out_index, 0);
            chk("rst_img", out_is_image, 0);
            chk("rst_done", sram_done, 0);
            chk("rst_busy", busy, 0);
        end else begin
            k      = have_f ? (cyc - s_m) : -1;
            e_ren  = have_f && k >= 1 && k <= n_m;
            e_val  = have_f && k >= L + 2 && k <= n_m + L + 1;
            e_done = have_f && k == n_m + L + 2;
            e_busy = have_f && k >= 1 && k <= n_m + L + 2;
            e_img  = (have_f && k >= 1) ? img_m : prev_img;
            chk("ren", sram_ren, e_ren);
            chk("valid", out_valid, e_val);
            chk("done", sram_done, e_done);
            chk("busy", busy, e_busy);
            chk("is_image", out_is_image, e_img);
            if (e_ren) chk("addr", sram_addr, 16'(base_m + k - 1));
            if (e_val) begin
                chk("data", out_data, 16'(base_m + k - L - 2) ^ 16'hA5A5);
                chk("index", out_index, k - L - 2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit st, input bit img);
        start_sram   = st;
        n_coef_image = img;
        if (st && !rst && (!have_f || cyc >= s_m + n_m + L + 3)) begin
            if (have_f) prev_img = img_m;
            have_f = 1'b1;
            s_m    = cyc;
            img_m  = img;
            n_m    = img ? IMG_N : COEF_N;
            base_m = img ? 0 : COEF_B + cs_m * COEF_N;
            cs_m   = img ? 0 : (cs_m + 1) % SETS;
        end
        tick();
        start_sram   = 1'b0;
        n_coef_image = 1'($urandom_range(0, 1));
    endtask

    task automatic do_rst(input int cycles);
        rst      = 1'b1;
        have_f   = 1'b0;
        cs_m     = 0;
        prev_img = 1'b0;
        #1;
        chk("arst_ren", sram_ren, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_index", out_index, 0);
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        for (int g = 0; g < 200 && have_f && cyc < s_m + n_m + L + 3; g++)
            drive(1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic start_chk_addr(input bit img, input int exp_addr, input string tag);
        wait_idle();
        drive(1'b1, img);
        @(negedge clk);
        chk(tag, sram_addr, exp_addr);
        tick();
    endtask

    initial begin
        int s0, d1, d4, c1, c4;
        n_chk = 0; n_pass = 0; cyc = 0;
        have_f = 0; img_m = 0; prev_img = 0; s_m = 0; n_m = 0; base_m = 0; cs_m = 0;
        rst = 1'b1; start_sram = 1'b0; n_coef_image = 1'b0; st1 = 1'b0; st4 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (4) drive(1'b0, 1'b1);

        // Image fetch, then coefficient wrap over two sets
        start_chk_addr(1'b1, 0, "img_start_addr");
        start_chk_addr(1'b0, 1024, "coef0_addr");
        start_chk_addr(1'b0, 1040, "coef1_addr");
        start_chk_addr(1'b0, 1024, "coef_wrap_addr");
        start_chk_addr(1'b1, 0, "img2_start_addr");
        start_chk_addr(1'b0, 1024, "coef_after_img_addr");

        // Start pulses while busy are dropped; first start after DONE is taken
        wait_idle();
        drive(1'b1, 1'b1);
        s0 = s_m;
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        while (cyc < s0 + IMG_N + L + 2) drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        @(negedge clk);
        chk("busy_accept_addr", sram_addr, 1024);
        tick();

        // Reset in cycle 3 of an image fetch
        wait_idle();
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        do_rst(2);
        repeat (8) drive(1'b0, 1'b1);
        start_chk_addr(1'b0, 1024, "coef_after_rst_addr");

        // Random traffic with occasional resets
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 149) == 0) do_rst($urandom_range(1, 2));
            else drive($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        end

        // Latency sweep, N=1 on both small instances
        wait_idle();
        st1 = 1'b1; st4 = 1'b1;
        s0 = cyc;
        tick();
        st1 = 1'b0; st4 = 1'b0;
        d1 = -1; d4 = -1; c1 = 0; c4 = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (val1) begin
                c1++;
                chk("l1_index", idx1, 0);
                chk("l1_data", data1, 16'hA5A5);
            end
            if (val4) begin
                c4++;
                chk("l4_index", idx4, 0);
                chk("l4_data", data4, 16'hA5A5);
            end
            if (done1 && d1 < 0) d1 = cyc - s0;
            if (done4 && d4 < 0) d4 = cyc - s0;
            tick();
        end
        chk("l1_done_cycle", d1, 4);
        chk("l4_done_cycle", d4, 7);
        chk("l1_valid_count", c1, 1);
        chk("l4_valid_count", c4, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
